// File: rtl/tpu_fp_pkg.sv
// FP32 field layout and the total-order key shared by the pooling comparators.
package tpu_fp_pkg;

  localparam int unsigned FP_SIGN_BIT = 31;
  localparam int unsigned FP_EXP_W    = 8;
  localparam int unsigned FP_MAN_W    = 23;
  localparam int unsigned FP_W        = 1 + FP_EXP_W + FP_MAN_W;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  // Positive words sit above all negatives; negatives invert so larger magnitude ranks lower.
  function automatic logic [FP_W-1:0] fp32_order_key(fp32_t d);
    logic [FP_W-1:0] raw;
    raw = d;
    fp32_order_key = raw[FP_SIGN_BIT] ? ~raw : {1'b1, raw[FP_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict greater-than on FP32 words using the pooling order key.
module fp32_gt
  import tpu_fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            gt
);

  assign gt = fp32_order_key(a) > fp32_order_key(b);

endmodule

// File: rtl/fp32_maxpool_stream.sv
// Streaming FP32 max-reduction: folds groups of WINDOW words (or shorter, closed by
// in_last) into the maximum value, its position and the group length.
module fp32_maxpool_stream
  import tpu_fp_pkg::*;
#(
  parameter int unsigned WINDOW = 4,
  parameter int unsigned IDX_W  = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [IDX_W-1:0] out_index,
  output logic [IDX_W:0]   out_count
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [FP_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             in_fire;
  logic             out_fire;
  logic             grp_first;
  logic             new_gt;
  logic             grp_close;
  logic [CNT_W-1:0] cnt_plus;
  logic [FP_W-1:0]  best_nxt;
  logic [IDX_W-1:0] idx_nxt;

  fp32_gt u_gt (
    .a  (in_data),
    .b  (best_q),
    .gt (new_gt)
  );

  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign grp_first = (cnt_q == '0);
  assign cnt_plus  = CNT_W'(cnt_q) + CNT_W'(1);
  assign grp_close = in_last || (cnt_plus == CNT_W'(WINDOW));

  // First element loads unconditionally; later ones replace only when strictly greater.
  assign best_nxt = (grp_first || new_gt) ? in_data : best_q;
  assign idx_nxt  = grp_first ? '0 : (new_gt ? cnt_q : best_idx_q);

  always_comb begin
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_count_d = out_count_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      best_d     = best_nxt;
      best_idx_d = idx_nxt;
      if (grp_close) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = best_nxt;
        out_index_d = idx_nxt;
        out_count_d = cnt_plus;
      end else begin
        cnt_d = cnt_plus[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_fp32_maxpool_stream.sv
// Directed and randomized checks for fp32_maxpool_stream with WINDOW=4.
module tb_fp32_maxpool_stream;

  localparam int unsigned WINDOW = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_index;
  logic [2:0]  out_count;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int n_res  = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  i;
    logic [2:0]  c;
  } res_t;

  res_t        exp_q[$];
  bit          soak_en = 1'b0;
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_best;

  fp32_maxpool_stream #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign-magnitude reference ordering, written independently of the key trick.
  function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  // Inputs only change #1 after posedge, so the negedge view predicts the next edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) xfers++;
    if (soak_en) begin
      if (out_valid && out_ready) begin
        res_t e;
        checks++;
        n_res++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL soak_extra: got %h/%0d/%0d with no result expected", out_data, out_index, out_count);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_index !== e.i || out_count !== e.c) begin
            errors++;
            $display("FAIL soak_result: got %h/%0d/%0d want %h/%0d/%0d",
                     out_data, out_index, out_count, e.d, e.i, e.c);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0 || ref_gt(in_data, m_best)) begin
          m_best = in_data;
          m_idx  = m_cnt;
        end
        m_cnt++;
        if (m_cnt == WINDOW || in_last) begin
          exp_q.push_back('{m_best, 2'(m_idx), 3'(m_cnt)});
          m_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0)   begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
    checks++; if (out_index !== 2'd0)   begin errors++; $display("FAIL rst_index: got %0d want 0", out_index); end
    checks++; if (out_count !== 3'd0)   begin errors++; $display("FAIL rst_count: got %0d want 0", out_count); end
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_group;
    out_ready = 1'b1;
    beat(32'h3F800000, 1'b0);
    beat(32'h40400000, 1'b0);
    beat(32'h40000000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %b want 0", out_valid); end
    beat(32'hBF800000, 1'b0);
    checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL full_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h40400000) begin errors++; $display("FAIL full_data: got %h want 40400000", out_data); end
    checks++; if (out_index !== 2'd1)        begin errors++; $display("FAIL full_index: got %0d want 1", out_index); end
    checks++; if (out_count !== 3'd4)        begin errors++; $display("FAIL full_count: got %0d want 4", out_count); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_signs_ties;
    beat(32'hC0000000, 1'b0);
    beat(32'h80000000, 1'b0);
    beat(32'h00000000, 1'b0);
    beat(32'h00000000, 1'b0);
    checks++; if (out_data !== 32'h00000000) begin errors++; $display("FAIL zero_data: got %h want 00000000", out_data); end
    checks++; if (out_index !== 2'd2)        begin errors++; $display("FAIL zero_index: got %0d want 2", out_index); end
    checks++; if (out_count !== 3'd4)        begin errors++; $display("FAIL zero_count: got %0d want 4", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_early_close;
    beat(32'hBF800000, 1'b0);
    beat(32'hC0000000, 1'b1);
    checks++; if (out_data !== 32'hBF800000) begin errors++; $display("FAIL early_data: got %h want BF800000", out_data); end
    checks++; if (out_index !== 2'd0)        begin errors++; $display("FAIL early_index: got %0d want 0", out_index); end
    checks++; if (out_count !== 3'd2)        begin errors++; $display("FAIL early_count: got %0d want 2", out_count); end
    // Single-element group accepted in the same cycle the previous result drains.
    beat(32'h3F800000, 1'b1);
    checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h3F800000) begin errors++; $display("FAIL single_data: got %h want 3F800000", out_data); end
    checks++; if (out_count !== 3'd1 || out_index !== 2'd0)
      begin errors++; $display("FAIL single_cnt_idx: got %0d/%0d want 1/0", out_count, out_index); end
    beat(32'h00000000, 1'b0);
    beat(32'h40A00000, 1'b0);
    beat(32'h40A00000, 1'b0);
    beat(32'h3F800000, 1'b0);
    checks++; if (out_data !== 32'h40A00000) begin errors++; $display("FAIL next_data: got %h want 40A00000", out_data); end
    checks++; if (out_index !== 2'd1)        begin errors++; $display("FAIL next_index: got %0d want 1", out_index); end
    checks++; if (out_count !== 3'd4)        begin errors++; $display("FAIL next_count: got %0d want 4", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int x0;
    x0 = xfers;
    out_ready = 1'b0;
    beat(32'h3F800000, 1'b0);
    beat(32'h40000000, 1'b0);
    beat(32'h40400000, 1'b0);
    beat(32'h40800000, 1'b0);
    in_valid = 1'b1; in_data = 32'h41000000; in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h40800000 || out_index !== 2'd3 ||
          out_count !== 3'd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b %h/%0d/%0d rdy=%b want v=1 40800000/3/4 rdy=0",
                 k, out_valid, out_data, out_index, out_count, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    beat(32'h40E00000, 1'b0);
    beat(32'h41100000, 1'b0);
    beat(32'h3F800000, 1'b0);
    checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL bp2_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h41100000) begin errors++; $display("FAIL bp2_data: got %h want 41100000", out_data); end
    checks++; if (out_index !== 2'd2 || out_count !== 3'd4)
      begin errors++; $display("FAIL bp2_idx_cnt: got %0d/%0d want 2/4", out_index, out_count); end
    @(posedge clk); #1;
    checks++; if (xfers - x0 !== 2) begin errors++; $display("FAIL bp_xfers: got %0d want 2", xfers - x0); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    beat(32'h41000000, 1'b0);
    beat(32'h41100000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h want 0", out_data); end
    checks++; if (out_index !== 2'd0) begin errors++; $display("FAIL mid_index: got %0d want 0", out_index); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", out_count); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(32'h40000000, 1'b0);
    beat(32'h40A00000, 1'b0);
    beat(32'h3F800000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fresh_early: got %b want 0", out_valid); end
    beat(32'h40400000, 1'b0);
    checks++; if (out_data !== 32'h40A00000) begin errors++; $display("FAIL fresh_data: got %h want 40A00000", out_data); end
    checks++; if (out_index !== 2'd1 || out_count !== 3'd4)
      begin errors++; $display("FAIL fresh_idx_cnt: got %0d/%0d want 1/4", out_index, out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_soak;
    logic [31:0] d;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_q.delete();
    m_cnt = 0; m_idx = 0; m_best = '0; n_res = 0;
    soak_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      d = $urandom;
      if (d[30:23] == 8'hFF) d[22:0] = '0;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 5) == 0);
      in_data   = d;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    soak_en = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL soak_pending: got %0d want 0", exp_q.size()); end
    checks++; if (n_res < 500)       begin errors++; $display("FAIL soak_results: got %0d want >=500", n_res); end
  endtask

  initial begin
    test_reset;
    test_full_group;
    test_signs_ties;
    test_early_close;
    test_backpressure;
    test_reset_mid;
    test_soak;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp32_maxpool_stream.md
# fp32_maxpool_stream

Streaming FP32 max-reduction unit for the TPU pooling path. Accepts FP32 words over a valid/ready stream, reduces each group of WINDOW consecutive words, or a shorter group terminated by `in_last`, to its maximum and the position of that maximum. Emits one result per group on a valid/ready output. It is the sequential counterpart to the combinational FP32 comparators in the vector datapath: those pick one of two operands, this block folds a whole stream.

## Interface
Parameters:
- `WINDOW`, default 4: elements per pooling group; legal range 2..256.
- `IDX_W`, default `$clog2(WINDOW)`: width of the index and count fields; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept the input word.
- `in_data`  in  32  FP32 word: sign [31], exponent [30:23], mantissa [22:0].
- `in_last`  in  1  qualified by `in_valid`; closes the current group early.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  maximum of the group, bit-exact copy of the winning input.
- `out_index`  out  IDX_W  0-based position of the maximum within its group.
- `out_count`  out  IDX_W+1  number of elements in the group (1..WINDOW).

## Operation
- **Input handshake.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **in_ready.** `in_ready = !out_valid || out_ready`. It is combinational, and it is the only path from the output side to the input side.
- **Ordering key.** Comparison uses a key of `{1'b1, d[30:0]}` when `d[31]==0`, and `~d` when `d[31]==1`. The key is compared as unsigned 32-bit. Consequences:
  - -0 ranks below +0.
  - Denormals are ordered correctly.
  - NaN is ordered by bit pattern; it is not special-cased.
- **Replacement rule.** The running maximum is replaced only when the new key is strictly greater. On ties the earliest index wins.
- **States.** There are two: EMPTY (`cnt==0`) and ACCUM (`cnt>0`). Output holding is tracked independently by `out_valid`.
- **First element of a group.** The element accepted in EMPTY loads `best=in_data`, `best_idx=0` and `cnt=1`, with no comparison.
- **Later elements.** An element accepted in ACCUM at position `p=cnt` updates `best` and `best_idx=p` if it is greater, then sets `cnt=cnt+1`.
- **Group close.** A group closes on the accepted element where `cnt+1==WINDOW` or `in_last==1`. That element is included in the reduction. On close:
  - `out_data` and `out_index` take the final best, including the closing element.
  - `out_count` takes `cnt+1`.
  - `out_valid` is set and `cnt` returns to 0 (EMPTY).
- **Single-element group.** `in_last` on the first element of a group gives `out_count=1` and `out_index=0`.
- **Simultaneous events.**
  - An output transfer and an input transfer in the same cycle are legal. The output is consumed and the new element starts or continues the next group.
  - If that input also closes a group (for example `WINDOW` reached, or `in_last` in EMPTY), `out_valid` stays 1 and the output registers load the new result.
- **Output stability.** While `out_valid && !out_ready`, `out_data`, `out_index` and `out_count` hold and `in_ready` is 0.
- **Reset.** Asserting `rst_n` low at any time, including mid-group, discards the partial group and any held result. Reset values:
  - `out_valid=0`, `out_data=0`, `out_index=0`, `out_count=0`.
  - `cnt=0`, `best=0`, `best_idx=0`.
  - `in_ready` reads 1, since `out_valid=0`.

## Timing
- **Latency.** `out_valid` rises on the clock edge that accepts the closing element, i.e. one cycle after that element is presented.
- **Throughput.** One element per cycle sustained whenever `out_ready` is 1 at each group close. With a constant `out_ready=1`, a WINDOW-element group produces one result every WINDOW cycles with no bubbles.
- **Critical path.** One 32-bit unsigned compare plus the `best` mux, then register. There is no multi-cycle path.
- **Registered outputs.** `out_valid`, `out_data`, `out_index` and `out_count` are registered. `in_ready` is the only combinational output.

## Structure
- **Package `tpu_fp_pkg`** holds:
  - FP32 field localparams: `FP_SIGN_BIT=31`, `FP_EXP_W=8`, `FP_MAN_W=23`.
  - The packed struct typedef `fp32_t` with fields sign, exp and man.
  - The function `fp32_order_key(fp32_t)` returning `logic [31:0]`.
- **Sub-module `fp32_gt`.** Combinational; ports `a`, `b` (32) and `gt` (1); computes `fp32_order_key(a) > fp32_order_key(b)`. It is instantiated once, comparing the incoming element against `best`.
- **Top level.** Contains the `cnt` counter, the `best`/`best_idx` registers, the output registers and the `in_ready` logic.

## Test plan
- **Full group, constant `out_ready=1`.** `WINDOW=4`; stream 3F800000, 40400000, 40000000, BF800000 (1, 3, 2, -1) → `out_data=40400000`, `out_index=1`, `out_count=4`, `out_valid` one cycle after the 4th element.
- **Signs, zeros and ties.** Group C0000000, 80000000, 00000000, 00000000 → `out_data=00000000`, `out_index=2`: +0 beats -0, and the earliest tie wins.
- **Early close.** `in_last` on the 2nd element (BF800000 then C0000000) → `out_data=BF800000`, `out_index=0`, `out_count=2`. The next element starts a new group at index 0.
- **Backpressure.** Hold `out_ready=0` for 5 cycles after a result → outputs stable and `in_ready=0` throughout. On release, the same-cycle input is accepted, and back-to-back groups yield no lost or duplicated results.
- **Reset mid-operation.** Pulse `rst_n` low asynchronously after 2 elements of a group → all outputs are 0 immediately, and the next 4 elements form a fresh group with the correct `out_index`.
- **Random soak.** 10k random FP32 words (NaN excluded) with random `in_valid`, `out_ready` and `in_last` → every result matches a reference-model max and first index.
